// File: rtl/flush_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// flush_redirect_ctrl
//
// Central flush / fetch-redirect controller for the 5-stage LoongArch core.
// Chooses between two redirect sources: a WB event (exception, ertn, or a
// qualified refetch), which always wins, and an EX taken branch. It also
// produces the per-stage flush pulses and holds the redirect PC until IF
// takes it. A count of outstanding instruction requests is kept so that
// responses to requests issued before a flush are marked for IF to drop.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   wb_ex, ertn_flush     WB exception / ertn
//   wb_refetch_flush      WB refetch request, qualified by wb_valid_i
//   wb_valid_i            WB stage valid
//   wb_flush_entry        WB redirect target
//   br_taken, br_target   EX taken branch and its target
//   inst_req_fire         IF request accepted this cycle
//   inst_data_ok          instruction response returned this cycle
//   redirect_ready        IF consumes the redirect this cycle
//   flush_all             flush IF/ID/EX/MEM (combinational)
//   flush_front           flush IF/ID only (combinational)
//   redirect_valid        redirect_pc is valid
//   redirect_pc           redirect target for IF
//   req_allow             IF may issue a new request
//   data_discard          current inst_data_ok must be dropped by IF
//   dbg_state_o           1 while a redirect is pending
//   dbg_oc_o, dbg_dc_o    outstanding / discard counters
//
// Handshake: the redirect is a valid/ready pair. Once redirect_valid rises,
// redirect_pc stays stable until a cycle with redirect_ready=1, unless a new
// flush event replaces it (the new event always wins over the handshake).
// ---------------------------------------------------------------------------
module flush_redirect_ctrl #(
  parameter int MAX_OUT = 2,
  parameter int OC_W    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_ex,
  input  logic            ertn_flush,
  input  logic            wb_refetch_flush,
  input  logic            wb_valid_i,
  input  logic [31:0]     wb_flush_entry,
  input  logic            br_taken,
  input  logic [31:0]     br_target,
  input  logic            inst_req_fire,
  input  logic            inst_data_ok,
  input  logic            redirect_ready,
  output logic            flush_all,
  output logic            flush_front,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc,
  output logic            req_allow,
  output logic            data_discard,
  output logic            dbg_state_o,
  output logic [OC_W-1:0] dbg_oc_o,
  output logic [OC_W-1:0] dbg_dc_o
);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_e;

  localparam logic [OC_W-1:0] MAX_C = OC_W'(MAX_OUT);
  localparam logic [OC_W-1:0] ONE_C = OC_W'(1);

  state_e          state_q, state_d;
  logic            pend_wb_q, pend_wb_d;
  logic [31:0]     pc_q, pc_d;
  logic [OC_W-1:0] oc_q, oc_d;
  logic [OC_W-1:0] dc_q, dc_d;

  logic wb_evt;
  logic br_evt;
  logic flush_evt;
  logic ok_eff;
  logic fire_eff;

  always_comb begin
    wb_evt    = wb_ex | ertn_flush | (wb_refetch_flush & wb_valid_i);
    // A branch behind a pending WB redirect is younger than the flushed
    // instruction and must not override it.
    br_evt    = br_taken & ~wb_evt & ~((state_q == PEND) & pend_wb_q);
    flush_evt = wb_evt | br_evt;

    // data_ok with nothing outstanding is ignored; a fire at the limit only
    // counts when a response frees a slot in the same cycle (no wrap).
    ok_eff   = inst_data_ok & (oc_q != '0);
    fire_eff = inst_req_fire & ((oc_q != MAX_C) | ok_eff);
  end

  // Redirect FSM next state
  always_comb begin
    state_d   = state_q;
    pend_wb_d = pend_wb_q;
    pc_d      = pc_q;
    if (wb_evt) begin
      state_d   = PEND;
      pend_wb_d = 1'b1;
      pc_d      = wb_flush_entry;
    end else if (br_evt) begin
      state_d   = PEND;
      pend_wb_d = 1'b0;
      pc_d      = br_target;
    end else if ((state_q == PEND) && redirect_ready) begin
      state_d   = IDLE;
      pend_wb_d = 1'b0;
    end
  end

  // Outstanding and discard counters
  always_comb begin
    oc_d = oc_q;
    if (fire_eff && !ok_eff) begin
      oc_d = oc_q + ONE_C;
    end else if (!fire_eff && ok_eff) begin
      oc_d = oc_q - ONE_C;
    end

    dc_d = dc_q;
    if (flush_evt) begin
      // Everything still in flight after this cycle belongs to the old path;
      // this cycle's data_ok has already been removed from oc_d.
      dc_d = oc_d;
    end else if (inst_data_ok && (dc_q != '0)) begin
      dc_d = dc_q - ONE_C;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pend_wb_q <= 1'b0;
      pc_q      <= 32'h0;
      oc_q      <= '0;
      dc_q      <= '0;
    end else begin
      state_q   <= state_d;
      pend_wb_q <= pend_wb_d;
      pc_q      <= pc_d;
      oc_q      <= oc_d;
      dc_q      <= dc_d;
    end
  end

  // Combinational outputs are forced low while reset is held.
  always_comb begin
    flush_all      = wb_evt & ~reset;
    flush_front    = br_evt & ~reset;
    redirect_valid = (state_q == PEND);
    redirect_pc    = pc_q;
    req_allow      = (oc_q < MAX_C) & ~flush_evt & ~reset;
    data_discard   = (dc_q != '0) & inst_data_ok & ~reset;
    dbg_state_o    = (state_q == PEND);
    dbg_oc_o       = oc_q;
    dbg_dc_o       = dc_q;
  end

endmodule

// File: tb/tb_flush_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_flush_redirect_ctrl
//
// Directed sequence followed by a short random stretch. A reference model
// keeps one flag per outstanding instruction request in exp_q (1 = belongs
// to a flushed path); each inst_data_ok pops the oldest flag and compares it
// with data_discard. Redirect state, pc and the combinational flush outputs
// are predicted by the same model.
// ---------------------------------------------------------------------------
module tb_flush_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_ex, ertn_flush, wb_refetch_flush, wb_valid_i;
  logic [31:0] wb_flush_entry;
  logic        br_taken;
  logic [31:0] br_target;
  logic        inst_req_fire, inst_data_ok, redirect_ready;
  logic        flush_all, flush_front, redirect_valid;
  logic [31:0] redirect_pc;
  logic        req_allow, data_discard;
  logic        dbg_state_o;
  logic [1:0]  dbg_oc_o, dbg_dc_o;

  int checks   = 0;
  int failures = 0;

  logic [0:0]  exp_q[$];
  logic        m_pend, m_pend_wb;
  logic [31:0] m_pc;

  flush_redirect_ctrl #(.MAX_OUT(2), .OC_W(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_ex            (wb_ex),
    .ertn_flush       (ertn_flush),
    .wb_refetch_flush (wb_refetch_flush),
    .wb_valid_i       (wb_valid_i),
    .wb_flush_entry   (wb_flush_entry),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .inst_req_fire    (inst_req_fire),
    .inst_data_ok     (inst_data_ok),
    .redirect_ready   (redirect_ready),
    .flush_all        (flush_all),
    .flush_front      (flush_front),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .req_allow        (req_allow),
    .data_discard     (data_discard),
    .dbg_state_o      (dbg_state_o),
    .dbg_oc_o         (dbg_oc_o),
    .dbg_dc_o         (dbg_dc_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int flagged();
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i] == 1'b1) n++;
    return n;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pend    = 1'b0;
    m_pend_wb = 1'b0;
    m_pc      = 32'h0;
  endtask

  // Driver tasks
  task automatic clr();
    wb_ex            = 1'b0;
    ertn_flush       = 1'b0;
    wb_refetch_flush = 1'b0;
    wb_valid_i       = 1'b0;
    wb_flush_entry   = 32'h0;
    br_taken         = 1'b0;
    br_target        = 32'h0;
    inst_req_fire    = 1'b0;
    inst_data_ok     = 1'b0;
    redirect_ready   = 1'b0;
  endtask

  // One clock cycle with the inputs already driven: combinational outputs
  // are checked at the falling edge, registered state 1 time unit after the
  // rising edge.
  task automatic cyc(input string tag);
    logic       wbe, ff;
    logic [0:0] f;
    @(negedge clk);
    wbe = wb_ex | ertn_flush | (wb_refetch_flush & wb_valid_i);
    ff  = br_taken & ~wbe & ~(m_pend & m_pend_wb);
    chk({tag, "/flush_all"},   flush_all, wbe);
    chk({tag, "/flush_front"}, flush_front, ff);
    chk({tag, "/req_allow"},   req_allow, (exp_q.size() < 2) & ~wbe & ~ff);
    chk({tag, "/rvalid"},      redirect_valid, m_pend);
    chk({tag, "/rpc"},         redirect_pc, m_pc);
    if (inst_data_ok && exp_q.size() > 0) begin
      f = exp_q.pop_front();
      chk({tag, "/discard"}, data_discard, f);
    end else begin
      chk({tag, "/discard_idle"}, data_discard, 1'b0);
    end
    if (inst_req_fire && exp_q.size() < 2) exp_q.push_back(1'b0);
    if (wbe || ff) foreach (exp_q[i]) exp_q[i] = 1'b1;
    if (wbe) begin
      m_pend = 1'b1; m_pend_wb = 1'b1; m_pc = wb_flush_entry;
    end else if (ff) begin
      m_pend = 1'b1; m_pend_wb = 1'b0; m_pc = br_target;
    end else if (m_pend && redirect_ready) begin
      m_pend = 1'b0; m_pend_wb = 1'b0;
    end
    @(posedge clk);
    #1;
    chk({tag, "/oc"},    dbg_oc_o, exp_q.size());
    chk({tag, "/dc"},    dbg_dc_o, flagged());
    chk({tag, "/state"}, dbg_state_o, m_pend);
  endtask

  task automatic fire1(input string tag);
    clr(); inst_req_fire = 1'b1; cyc(tag);
  endtask

  task automatic ok1(input string tag);
    clr(); inst_data_ok = 1'b1; cyc(tag);
  endtask

  task automatic ready1(input string tag);
    clr(); redirect_ready = 1'b1; cyc(tag);
  endtask

  initial begin
    // Reset: drive active inputs to confirm outputs stay low
    model_reset();
    clr();
    reset = 1'b1;
    wb_ex = 1'b1; br_taken = 1'b1; inst_data_ok = 1'b1;
    #2;
    chk("rst/flush_all",   flush_all, 1'b0);
    chk("rst/flush_front", flush_front, 1'b0);
    chk("rst/rvalid",      redirect_valid, 1'b0);
    chk("rst/rpc",         redirect_pc, 32'h0);
    chk("rst/req_allow",   req_allow, 1'b0);
    chk("rst/discard",     data_discard, 1'b0);
    chk("rst/oc",          dbg_oc_o, 2'd0);
    chk("rst/dc",          dbg_dc_o, 2'd0);
    @(posedge clk); #1;
    clr();
    reset = 1'b0;

    // Idle branch
    clr(); br_taken = 1'b1; br_target = 32'h1c00_0100; cyc("br");
    chk("br/pc_direct", redirect_pc, 32'h1c00_0100);
    clr(); cyc("br_hold0");
    clr(); cyc("br_hold1");
    ready1("br_take");
    clr(); cyc("br_idle");

    // Exception with two outstanding
    fire1("ex_f0");
    fire1("ex_f1");
    clr(); wb_ex = 1'b1; wb_flush_entry = 32'h1c00_8000; cyc("ex");
    chk("ex/dc_direct", dbg_dc_o, 2'd2);
    clr(); inst_data_ok = 1'b1; redirect_ready = 1'b1; cyc("ex_d0");
    ok1("ex_d1");
    chk("ex/oc_zero", dbg_oc_o, 2'd0);
    fire1("ex_new");
    chk("ex/oc_one", dbg_oc_o, 2'd1);
    ok1("ex_new_ok");

    // Priority: WB beats branch, younger branch ignored
    clr(); wb_ex = 1'b1; wb_flush_entry = 32'h1c00_0400;
    br_taken = 1'b1; br_target = 32'h1c00_0500; cyc("prio");
    clr(); br_taken = 1'b1; br_target = 32'h1c00_0600; cyc("prio_young");
    chk("prio/pc_kept", redirect_pc, 32'h1c00_0400);
    ready1("prio_take");

    // Override: ertn replaces branch redirect while IF is taking it
    clr(); br_taken = 1'b1; br_target = 32'h100; cyc("ovr_br");
    clr(); ertn_flush = 1'b1; wb_flush_entry = 32'h200; redirect_ready = 1'b1;
    cyc("ovr_ertn");
    chk("ovr/pc", redirect_pc, 32'h200);
    ready1("ovr_take");

    // Refetch only honoured with wb_valid_i
    clr(); wb_refetch_flush = 1'b1; wb_flush_entry = 32'h300; cyc("rf_nov");
    clr(); wb_refetch_flush = 1'b1; wb_valid_i = 1'b1; wb_flush_entry = 32'h304;
    cyc("rf_v");
    ready1("rf_take");

    // Counter boundaries
    fire1("cb_f");
    clr(); inst_req_fire = 1'b1; inst_data_ok = 1'b1; cyc("cb_both");
    ok1("cb_ok");
    ok1("cb_ok_empty");
    fire1("cb_f1");
    clr(); br_taken = 1'b1; br_target = 32'h1c00_0700; inst_req_fire = 1'b1;
    cyc("cb_flush_fire");
    chk("cb/dc_two", dbg_dc_o, 2'd2);
    clr(); inst_data_ok = 1'b1; redirect_ready = 1'b1; cyc("cb_d0");
    ok1("cb_d1");

    // Random stretch
    for (int n = 0; n < 300; n++) begin
      clr();
      inst_req_fire    = (exp_q.size() < 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      inst_data_ok     = 1'($urandom_range(0, 1));
      br_taken         = ($urandom_range(0, 5) == 0);
      br_target        = $urandom;
      wb_ex            = ($urandom_range(0, 11) == 0);
      ertn_flush       = ($urandom_range(0, 15) == 0);
      wb_refetch_flush = ($urandom_range(0, 9) == 0);
      wb_valid_i       = 1'($urandom_range(0, 1));
      wb_flush_entry   = $urandom;
      redirect_ready   = 1'($urandom_range(0, 1));
      cyc("rnd");
    end
    for (int n = 0; n < 3; n++) begin
      clr(); inst_data_ok = 1'b1; redirect_ready = 1'b1; cyc("drain");
    end

    // Asynchronous reset while pending with one response to discard
    fire1("ar_f");
    clr(); br_taken = 1'b1; br_target = 32'h1c00_0900; cyc("ar_br");
    chk("ar/dc_one", dbg_dc_o, 2'd1);
    clr(); inst_data_ok = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("ar/rvalid",  redirect_valid, 1'b0);
    chk("ar/discard", data_discard, 1'b0);
    chk("ar/oc",      dbg_oc_o, 2'd0);
    chk("ar/dc",      dbg_dc_o, 2'd0);
    chk("ar/rpc",     redirect_pc, 32'h0);
    model_reset();
    @(posedge clk); #1;
    clr();
    reset = 1'b0;
    fire1("post_rst");
    ok1("post_rst_ok");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flush_redirect_ctrl.md
Name: flush_redirect_ctrl

Overview:
- Central pipeline-flush and fetch-redirect controller for the 5-stage LoongArch core.
- Arbitrates redirect sources:
  - WB exception / ertn / refetch (highest priority).
  - EX branch (lower priority).
- Drives the per-stage flush pulse and holds the redirect PC until IF accepts it.
- Tracks outstanding instruction-SRAM/AXI requests, so that responses issued before a flush are discarded instead of entering IF.

Parameters:
- MAX_OUT, 2, maximum outstanding inst requests allowed.
- OC_W, 2, width of the outstanding and discard counters; must hold MAX_OUT.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- wb_ex  in  1  valid exception in WB.
- ertn_flush  in  1  valid ertn in WB.
- wb_refetch_flush  in  1  TLB op / CSR write needing refetch; only honoured when qualified by wb_valid_i.
- wb_valid_i  in  1  WB stage valid.
- wb_flush_entry  in  32  WB redirect target.
- br_taken  in  1  EX branch resolved taken.
- br_target  in  32  EX branch target.
- inst_req_fire  in  1  IF request accepted (req & addr_ok).
- inst_data_ok  in  1  inst response returned.
- redirect_ready  in  1  IF consumes redirect this cycle.
- flush_all  out  1  flush IF/ID/EX/MEM (WB self-clears).
- flush_front  out  1  flush IF/ID only (branch).
- redirect_valid  out  1  redirect_pc is valid.
- redirect_pc  out  32  target for IF.
- req_allow  out  1  IF may issue a new request.
- data_discard  out  1  current inst_data_ok must be dropped by IF.

Behaviour:
- wb_evt = wb_ex | ertn_flush | (wb_refetch_flush & wb_valid_i).
- flush_all = wb_evt, combinational, same cycle.
- flush_front = br_taken & ~wb_evt & ~(state==PEND & pend_wb).
- All outputs are 0 while reset is asserted. Reset register values:
  - state=IDLE, pend_wb=0, redirect_pc=0.
  - oc=0, dc=0.
- Reset asserted mid-operation clears a pending redirect and all counts immediately (asynchronous).
- States:
  - IDLE: no pending redirect.
  - PEND: redirect_valid=1, redirect_pc held stable.
- Transitions:
  - IDLE & wb_evt -> PEND; pc=wb_flush_entry, pend_wb=1.
  - IDLE & br_taken (no wb_evt) -> PEND; pc=br_target, pend_wb=0.
  - PEND & wb_evt -> PEND; pc=wb_flush_entry, pend_wb=1. WB always overrides.
  - PEND & br_taken & ~pend_wb & ~wb_evt -> overwrite with br_target.
  - PEND & br_taken & pend_wb -> branch ignored, since it is younger than the flushed WB instruction.
  - PEND & redirect_ready & no new event -> IDLE.
  - Event and redirect_ready in the same cycle: the new event wins and the state stays PEND with the new pc.
- Latency:
  - flush_all / flush_front: 0 cycles.
  - redirect_valid: 1 cycle after the event.
- Outstanding counter oc:
  - +1 on inst_req_fire, -1 on inst_data_ok; both in the same cycle -> unchanged.
  - req_allow = (oc < MAX_OUT) & ~flush_all & ~flush_front.
  - inst_req_fire while oc==MAX_OUT is a protocol error; oc saturates and does not wrap.
  - inst_data_ok while oc==0 is ignored; no underflow.
- Discard counter dc (responses are in-order):
  - data_discard = (dc != 0) & inst_data_ok.
  - On a flush event (flush_all or flush_front): dc <= oc_next_excluding_discard, i.e. oc + inst_req_fire − inst_data_ok.
  - The current cycle's data_ok is consumed normally unless dc != 0, in which case it is discarded and also counted.
  - Otherwise dc decrements on each inst_data_ok while dc != 0.
  - dc <= oc at all times; oc decrements on every data_ok, including discarded ones.
- Requests issued after the redirect are never discarded. IF may issue them while dc>0, subject to req_allow.

Test Plan:
- Idle branch:
  - Stimulus: br_taken=1, br_target=0x1c000100, oc=0.
  - Response: flush_front=1 that cycle; next cycle redirect_valid=1, redirect_pc=0x1c000100; holds until redirect_ready, then IDLE; data_discard never asserted.
- Exception with 2 outstanding:
  - Stimulus: oc=2, wb_ex=1, entry=0x1c008000.
  - Response: flush_all=1, req_allow=0 that cycle; dc=2; next two inst_data_ok give data_discard=1; the third (new fetch) gives data_discard=0; oc returns to 0 then to 1.
- Priority:
  - Stimulus: wb_ex and br_taken in the same cycle.
  - Response: flush_front=0, redirect_pc=wb_flush_entry.
  - Stimulus: later br_taken while PEND with pend_wb=1.
  - Response: pc unchanged.
- Override:
  - Stimulus: PEND with branch pc 0x100, ertn_flush=1, entry 0x200, redirect_ready=1 the same cycle.
  - Response: stays PEND, redirect_pc=0x200.
- Counter boundaries:
  - Stimulus: fire+data_ok in the same cycle.
  - Response: oc unchanged.
  - Stimulus: oc=2.
  - Response: req_allow=0.
  - Stimulus: data_ok at oc=0.
  - Response: oc stays 0.
  - Stimulus: flush with simultaneous fire at oc=1 and no data_ok.
  - Response: dc=2.
- Async reset:
  - Stimulus: assert reset between clock edges while PEND, dc=1.
  - Response: redirect_valid, data_discard, oc, dc go to 0 immediately.
